// File: rtl/stopwatch_display.sv
// -----------------------------------------------------------------------------
// stopwatch_display
//
// BCD stopwatch (SS.CC) driving a 4-digit, active-low, multiplexed
// seven-segment display. It runs entirely on the system clock. The 100 Hz
// level clock from the generator is sampled and edge-detected here, so it
// acts only as a count enable.
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       asynchronous, active-low reset
//   tick_in     100 Hz level clock; each rising edge is one centisecond
//   scan_sel    digit scan select from the clock generator
//   start_stop  single-cycle pulse: IDLE->RUN, RUN/LAP->PAUSE, PAUSE->RUN
//   lap_clear   single-cycle pulse: RUN->LAP (freeze), LAP->RUN,
//               PAUSE->IDLE (clear)
//   running     high in RUN or LAP
//   lap_active  high in LAP
//   wrap        one-cycle pulse when the count rolls over to 00.00
//   count_bcd   live count {sec_tens, sec_ones, cs_tens, cs_ones}
//   an          registered digit enables, active-low
//   seg         registered segments {a,b,c,d,e,f,g,dp}, active-low
// -----------------------------------------------------------------------------
module stopwatch_display #(
    parameter logic [2:0] SEC_TENS_MAX = 3'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic [1:0]  scan_sel,
    input  logic        start_stop,
    input  logic        lap_clear,
    output logic        running,
    output logic        lap_active,
    output logic        wrap,
    output logic [15:0] count_bcd,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        tick_prev_q;
    logic [15:0] count_q, count_d;
    logic [15:0] frozen_q, frozen_d;
    logic        wrap_q, wrap_d;
    logic        running_q, lap_active_q;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;

    logic        tick_pulse;
    logic        counting;
    logic [16:0] inc_res;
    logic [15:0] disp;
    logic [3:0]  nib;

    // BCD increment of {sec_tens, sec_ones, cs_tens, cs_ones}.
    // Bit 16 of the result flags the rollover from the maximum back to zero.
    function automatic logic [16:0] bcd_inc(input logic [15:0] c);
        logic [3:0] d0, d1, d2, d3;
        logic       wr;
        d0 = c[3:0];
        d1 = c[7:4];
        d2 = c[11:8];
        d3 = c[15:12];
        wr = 1'b0;
        if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                if (d2 != 4'd9) begin
                    d2 = d2 + 4'd1;
                end else begin
                    d2 = 4'd0;
                    if (d3 < {1'b0, SEC_TENS_MAX}) begin
                        d3 = d3 + 4'd1;
                    end else begin
                        d3 = 4'd0;
                        wr = 1'b1;
                    end
                end
            end
        end
        return {wr, d3, d2, d1, d0};
    endfunction

    // Active-low {a,b,c,d,e,f,g}; non-decimal nibbles are blanked.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Rising edge of the sampled 100 Hz level; the increment lands on the
    // same edge at which tick_prev_q goes high.
    assign tick_pulse = tick_in & ~tick_prev_q;
    // Counting is qualified by the pre-transition state, so a tick that
    // coincides with start_stop in RUN still counts, and in PAUSE does not.
    assign counting   = tick_pulse && ((state_q == S_RUN) || (state_q == S_LAP));
    assign inc_res    = bcd_inc(count_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        frozen_d = frozen_q;
        wrap_d   = 1'b0;

        if (counting) begin
            count_d = inc_res[15:0];
            wrap_d  = inc_res[16];
        end

        // start_stop is tested first everywhere, so a coincident lap_clear
        // is simply dropped.
        case (state_q)
            S_IDLE: begin
                if (start_stop) state_d = S_RUN;
            end
            S_RUN: begin
                if (start_stop) begin
                    state_d = S_PAUSE;
                end else if (lap_clear) begin
                    state_d  = S_LAP;
                    frozen_d = count_q;
                end
            end
            S_LAP: begin
                if (start_stop) begin
                    state_d = S_PAUSE;
                end else if (lap_clear) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (start_stop) begin
                    state_d = S_RUN;
                end else if (lap_clear) begin
                    state_d = S_IDLE;
                    count_d = 16'h0000;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The frozen lap value is shown only while LAP is active.
    assign disp = (state_q == S_LAP) ? frozen_q : count_q;

    always_comb begin
        an_d = 4'b1111;
        nib  = 4'd0;
        case (scan_sel)
            2'b00: begin an_d = 4'b1110; nib = disp[3:0];   end
            2'b01: begin an_d = 4'b1101; nib = disp[7:4];   end
            2'b10: begin an_d = 4'b1011; nib = disp[11:8];  end
            default: begin an_d = 4'b0111; nib = disp[15:12]; end
        endcase
        // Decimal point sits after the seconds-ones digit.
        seg_d = {seg7(nib), (scan_sel != 2'b10)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tick_prev_q  <= 1'b0;
            count_q      <= 16'h0000;
            frozen_q     <= 16'h0000;
            wrap_q       <= 1'b0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            tick_prev_q  <= tick_in;
            count_q      <= count_d;
            frozen_q     <= frozen_d;
            wrap_q       <= wrap_d;
            running_q    <= (state_d == S_RUN) || (state_d == S_LAP);
            lap_active_q <= (state_d == S_LAP);
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign wrap       = wrap_q;
    assign count_bcd  = count_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

    logic        clk;
    logic        reset;
    logic        tick_in;
    logic [1:0]  scan_sel;
    logic        start_stop;
    logic        lap_clear;
    logic        running;
    logic        lap_active;
    logic        wrap;
    logic [15:0] count_bcd;
    logic [3:0]  an;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic [7:0] seg;
    } scan_vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } disp_exp_t;

    scan_vec_t vecs[4];
    disp_exp_t sb_q[$];

    stopwatch_display #(.SEC_TENS_MAX(3'd5)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .scan_sel   (scan_sel),
        .start_stop (start_stop),
        .lap_clear  (lap_clear),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap),
        .count_bcd  (count_bcd),
        .an         (an),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock, then settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic pulse_lc();
        lap_clear = 1'b1;
        step();
        lap_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Walk all four scan positions; the expected digit drive is queued when
    // scan_sel is applied and compared once the registered output appears.
    task automatic scan_check(input logic [15:0] v, input string tag);
        disp_exp_t e, got;
        for (int s = 0; s < 4; s++) begin
            scan_sel = s[1:0];
            e.an  = ~(4'b0001 << s);
            e.seg = {seg_of(v[4*s +: 4]), (s != 2)};
            sb_q.push_back(e);
            step();
            got = sb_q.pop_front();
            check($sformatf("%s_an%0d", tag, s), {28'd0, an}, {28'd0, got.an});
            check($sformatf("%s_seg%0d", tag, s), {24'd0, seg}, {24'd0, got.seg});
        end
    endtask

    initial begin
        disp_exp_t e, got;
        vecs[0] = '{sel: 2'b00, an: 4'b1110, seg: 8'b00011111};
        vecs[1] = '{sel: 2'b01, an: 4'b1101, seg: 8'b10011001};
        vecs[2] = '{sel: 2'b10, an: 4'b1011, seg: 8'b00001100};
        vecs[3] = '{sel: 2'b11, an: 4'b0111, seg: 8'b00000011};

        reset = 1'b0; tick_in = 1'b0; scan_sel = 2'b00;
        start_stop = 1'b0; lap_clear = 1'b0;
        step();
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_count", {16'd0, count_bcd}, 32'h0);
        check("rst_running", {31'd0, running}, 0);
        check("rst_lap", {31'd0, lap_active}, 0);
        check("rst_wrap", {31'd0, wrap}, 0);
        reset = 1'b1;
        step();

        // lap_clear in IDLE is ignored; ticks do not count in IDLE.
        pulse_lc();
        tick();
        check("idle_lc_running", {31'd0, running}, 0);
        check("idle_lc_lap", {31'd0, lap_active}, 0);
        check("idle_count", {16'd0, count_bcd}, 32'h0);

        // Basic counting.
        pulse_ss();
        check("start_running", {31'd0, running}, 1);
        repeat (5) tick();
        check("five_ticks", {16'd0, count_bcd}, 32'h0005);
        // Held-high tick counts only once.
        tick_in = 1'b1;
        repeat (6) step();
        tick_in = 1'b0;
        step();
        check("held_tick", {16'd0, count_bcd}, 32'h0006);

        // Wraparound at 59.99.
        do_reset();
        pulse_ss();
        repeat (5999) tick();
        check("pre_wrap", {16'd0, count_bcd}, 32'h5999);
        check("pre_wrap_flag", {31'd0, wrap}, 0);
        tick_in = 1'b1;
        step();
        check("wrap_count", {16'd0, count_bcd}, 32'h0000);
        check("wrap_high", {31'd0, wrap}, 1);
        tick_in = 1'b0;
        step();
        check("wrap_one_clk", {31'd0, wrap}, 0);
        tick();
        check("after_wrap", {16'd0, count_bcd}, 32'h0001);

        // Lap freeze.
        do_reset();
        pulse_ss();
        repeat (12) tick();
        pulse_lc();
        check("lap_active", {31'd0, lap_active}, 1);
        check("lap_running", {31'd0, running}, 1);
        repeat (30) tick();
        check("lap_live", {16'd0, count_bcd}, 32'h0042);
        scan_check(16'h0012, "lap_disp");
        pulse_lc();
        check("unlap_lap", {31'd0, lap_active}, 0);
        check("unlap_running", {31'd0, running}, 1);
        scan_check(16'h0042, "live_disp");

        // Both buttons in RUN: start_stop wins, no LAP.
        start_stop = 1'b1; lap_clear = 1'b1;
        step();
        start_stop = 1'b0; lap_clear = 1'b0;
        check("both_running", {31'd0, running}, 0);
        check("both_lap", {31'd0, lap_active}, 0);

        // Stop coincident with tick.
        do_reset();
        pulse_ss();
        repeat (9) tick();
        tick_in = 1'b1; start_stop = 1'b1;
        step();
        start_stop = 1'b0; tick_in = 1'b0;
        step();
        check("stop_tick_count", {16'd0, count_bcd}, 32'h0010);
        check("stop_tick_pause", {31'd0, running}, 0);
        repeat (3) tick();
        check("pause_hold", {16'd0, count_bcd}, 32'h0010);
        // Resume coincident with tick: no increment.
        tick_in = 1'b1; start_stop = 1'b1;
        step();
        start_stop = 1'b0; tick_in = 1'b0;
        step();
        check("resume_tick_count", {16'd0, count_bcd}, 32'h0010);
        check("resume_running", {31'd0, running}, 1);
        pulse_ss();
        pulse_lc();
        step();
        check("clear_count", {16'd0, count_bcd}, 32'h0000);
        check("clear_idle", {31'd0, running}, 0);

        // Scan decode table at 03.47.
        do_reset();
        pulse_ss();
        repeat (347) tick();
        pulse_ss();
        check("scan_count", {16'd0, count_bcd}, 32'h0347);
        for (int i = 0; i < 4; i++) begin
            scan_sel = vecs[i].sel;
            e.an  = vecs[i].an;
            e.seg = vecs[i].seg;
            sb_q.push_back(e);
            step();
            got = sb_q.pop_front();
            check($sformatf("tbl_an%0d", i), {28'd0, an}, {28'd0, got.an});
            check($sformatf("tbl_seg%0d", i), {24'd0, seg}, {24'd0, got.seg});
        end

        // Asynchronous reset mid-RUN.
        do_reset();
        pulse_ss();
        repeat (50) tick();
        check("pre_areset", {16'd0, count_bcd}, 32'h0050);
        #2 reset = 1'b0;
        #1;
        check("areset_an", {28'd0, an}, 32'hF);
        check("areset_seg", {24'd0, seg}, 32'hFF);
        check("areset_count", {16'd0, count_bcd}, 32'h0);
        check("areset_running", {31'd0, running}, 0);
        step();
        reset = 1'b1;
        step();
        repeat (3) tick();
        check("post_reset_idle", {16'd0, count_bcd}, 32'h0000);
        pulse_ss();
        tick();
        check("post_reset_run", {16'd0, count_bcd}, 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Consumer stage directly downstream of the team's clock generator. Runs entirely on the system clock `clk`.
- Takes two inputs from the generator: the 100 Hz level clock, used as a sampled enable (never as a clock), and the 2-bit seven-segment scan select.
- Maintains a BCD stopwatch SS.CC (seconds.centiseconds) with start/stop and lap/clear control.
- Drives a 4-digit active-low multiplexed seven-segment display.

Parameters:
- SEC_TENS_MAX, 3'd5, highest value of the seconds-tens digit. Count wraps after SEC_TENS_MAX,9.99.

Ports:
- clk  input  1  system clock; all registers update on posedge.
- reset  input  1  asynchronous, active-low reset.
- tick_in  input  1  100 Hz level clock from the generator; its rising edge is one count event.
- scan_sel  input  2  digit scan select from the generator.
- start_stop  input  1  single-cycle pulse, debounced upstream.
- lap_clear  input  1  single-cycle pulse, debounced upstream.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- wrap  output  1  one-cycle pulse when the count rolls over to 00.00.
- count_bcd  output  16  live count {sec_tens, sec_ones, cs_tens, cs_ones}, 4 bits each.
- an  output  4  digit enables, active-low, registered.
- seg  output  8  {a,b,c,d,e,f,g,dp}, active-low, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; count_bcd=16'h0000; frozen display register=16'h0000.
  - tick_prev=0; wrap=0; an=4'b1111; seg=8'hFF.
- Tick detect:
  - tick_prev <= tick_in every clk.
  - tick_pulse = tick_in & ~tick_prev.
  - A counting increment takes effect on the same clk edge at which tick_prev goes 1, i.e. one clk after tick_in rises.
- Counting:
  - Occurs on tick_pulse when the current state is RUN or LAP; the evaluated state is the pre-transition state.
  - cs_ones 0..9; carry to cs_tens 0..9; carry to sec_ones 0..9; carry to sec_tens 0..SEC_TENS_MAX.
  - At {SEC_TENS_MAX,9,9,9} the next increment gives 0000 and wrap=1 for exactly that one clk.
  - Counting continues after a wrap.
- FSM transitions (evaluated each clk):
  - IDLE: start_stop -> RUN. lap_clear is ignored. Count is held at 0.
  - RUN: start_stop -> PAUSE. lap_clear -> LAP, and the frozen register loads the live count on that same edge.
  - LAP: start_stop -> PAUSE and the freeze is released. lap_clear -> RUN and the freeze is released. Counting continues throughout LAP.
  - PAUSE: start_stop -> RUN. lap_clear -> IDLE, and count_bcd=0000 on the next edge. No counting.
- Priority and simultaneous events:
  - start_stop and lap_clear in the same cycle: start_stop wins and lap_clear is dropped.
  - tick_pulse coincident with start_stop in RUN: the increment is applied and the state becomes PAUSE.
  - tick_pulse coincident with start_stop in PAUSE: no increment; the state becomes RUN.
- Display source:
  - In LAP, digits come from the frozen register; otherwise from the live count.
- Scan (registered, one clk after scan_sel):
  - 00: an=1110, cs_ones.
  - 01: an=1101, cs_tens.
  - 10: an=1011, sec_ones, with dp on (seg[0]=0).
  - 11: an=0111, sec_tens.
  - dp is off for all other digits.
- Segment decode (active-low, {a..g}; dp shown as the trailing bit):
  - 0=0000001
  - 1=1001111
  - 2=0010010
  - 3=0000110
  - 4=1001100
  - 5=0100100
  - 6=0100000
  - 7=0001111
  - 8=0000000
  - 9=0000100
  - Nibble values 10-15 are blank (all 1).
- Reset mid-operation:
  - Asserting reset in any state returns to the reset values immediately.
  - After release, the first tick_in rising edge is counted only once start_stop has been pulsed.
- tick_in held high: no further increments (edge-only counting).

Test Plan:
- Reset, then start_stop pulse, then 5 tick_in rising edges -> count_bcd=16'h0005, running=1, state RUN.
- Preload to 59.99 via ticks (SEC_TENS_MAX=5), one more tick -> count_bcd=16'h0000, wrap high for exactly 1 clk, counting continues.
- RUN at 00.12, lap_clear, then 30 ticks -> count_bcd=16'h0042 while the displayed digits show 0012. Second lap_clear -> display shows 0042, lap_active=0.
- RUN, start_stop coincident with tick_pulse at 00.09 -> count_bcd=16'h0010, state PAUSE. Further ticks leave 0010. lap_clear -> 0000, state IDLE.
- count_bcd=16'h0347, cycle scan_sel 00,01,10,11 -> one clk later an/seg = 1110/00011111, 1101/10011001, 1011/00001100, 0111/00000011.
- Assert reset mid-RUN at 00.50 -> an=1111, seg=FF, count 0000 asynchronously. After release, ticks without start_stop leave the count at 0000.
